// File: rtl/snn_network_core.sv
// snn_network_core: eight leaky integrate-and-fire neurons that share one 16-bit
// input spike vector. Weights are fixed by parameter. Every neuron updates in
// parallel on each rising clock edge.
module snn_network_core #(
  parameter int unsigned VW         = 12,
  parameter int unsigned THRESHOLD  = 16,
  parameter int unsigned LEAK_SHIFT = 3,
  // W[j][i] lives at bits [4*(16*j+i) +: 4]. Neuron j gets +3 from inputs 2j and 2j+1
  // and -1 from every other input.
  parameter logic [511:0] WEIGHTS = {
    64'h33FF_FFFF_FFFF_FFFF,
    64'hFF33_FFFF_FFFF_FFFF,
    64'hFFFF_33FF_FFFF_FFFF,
    64'hFFFF_FF33_FFFF_FFFF,
    64'hFFFF_FFFF_33FF_FFFF,
    64'hFFFF_FFFF_FF33_FFFF,
    64'hFFFF_FFFF_FFFF_33FF,
    64'hFFFF_FFFF_FFFF_FF33
  }
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_signal,
  output logic [7:0]  out_spk
);

  localparam int unsigned NumNeurons = 8;
  localparam int unsigned NumInputs  = 16;
  // Signed working width. It must hold VW+2 bits for the potential path and at least
  // 10 bits for the synaptic sum, which spans -128..+112.
  localparam int unsigned NW = (VW + 2 > 10) ? VW + 2 : 10;

  // Membrane potentials. The bench may observe these hierarchically.
  logic [VW-1:0] v_q [NumNeurons];
  logic [VW-1:0] v_d [NumNeurons];
  logic [7:0]    spk_d;

  logic signed [NW-1:0] cur    [NumNeurons];
  logic signed [NW-1:0] vn     [NumNeurons];
  logic        [VW-1:0] vclamp [NumNeurons];

  // Synaptic current: sum the sign-extended weights of all active inputs.
  always_comb begin
    for (int j = 0; j < NumNeurons; j++) begin
      cur[j] = '0;
      for (int i = 0; i < NumInputs; i++) begin
        if (in_signal[i]) begin
          cur[j] = cur[j] + {{(NW-4){WEIGHTS[4*(16*j+i)+3]}}, WEIGHTS[4*(16*j+i) +: 4]};
        end
      end
    end
  end

  // Leak, integrate, clamp to [0, 2^VW-1], then apply the fire-and-reset rule.
  always_comb begin
    spk_d = '0;
    for (int j = 0; j < NumNeurons; j++) begin
      vn[j] = $signed({{(NW-VW){1'b0}}, v_q[j]})
            - $signed({{(NW-VW){1'b0}}, v_q[j] >> LEAK_SHIFT})
            + cur[j];
      if (vn[j][NW-1]) begin
        vclamp[j] = '0;
      end else if (|vn[j][NW-2:VW]) begin
        vclamp[j] = '1;
      end else begin
        vclamp[j] = vn[j][VW-1:0];
      end
      // Compared in 32 bits so that a THRESHOLD above 2^VW-1 never fires. VW stays below 32.
      if (32'(vclamp[j]) >= THRESHOLD) begin
        spk_d[j] = 1'b1;
        v_d[j]   = '0;
      end else begin
        v_d[j]   = vclamp[j];
      end
    end
  end

  // State and registered spike outputs. Reset wins over the input sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_spk <= '0;
      for (int j = 0; j < NumNeurons; j++) begin
        v_q[j] <= '0;
      end
    end else begin
      out_spk <= spk_d;
      for (int j = 0; j < NumNeurons; j++) begin
        v_q[j] <= v_d[j];
      end
    end
  end

endmodule

// File: tb/tb_snn_network_core.sv
// Randomised and directed bench for snn_network_core. It uses a behavioural LIF model
// written in plain integer arithmetic.
module tb_snn_network_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_signal;
  logic [7:0]  out_spk;

  int checks   = 0;
  int failures = 0;

  // Reference state.
  int          m_v [8];
  logic [7:0]  m_spk;

  snn_network_core dut (
    .clk       (clk),
    .reset     (reset),
    .in_signal (in_signal),
    .out_spk   (out_spk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp,
               $time);
    end
  endtask

  function automatic int weight(input int j, input int i);
    return ((i / 2) == j) ? 3 : -1;
  endfunction

  // Advance the model by one edge.
  task automatic model_edge(input logic [15:0] in, input logic rst);
    int cur, vn;
    for (int j = 0; j < 8; j++) begin
      if (rst) begin
        m_v[j]   = 0;
        m_spk[j] = 1'b0;
      end else begin
        cur = 0;
        for (int i = 0; i < 16; i++) if (in[i]) cur += weight(j, i);
        vn = m_v[j] - (m_v[j] / 8) + cur;
        if (vn < 0) vn = 0;
        if (vn > 4095) vn = 4095;
        if (vn >= 16) begin
          m_spk[j] = 1'b1;
          m_v[j]   = 0;
        end else begin
          m_spk[j] = 1'b0;
          m_v[j]   = vn;
        end
      end
    end
  endtask

  // Drive one cycle, then compare the DUT against the model after the edge.
  task automatic step(input logic [15:0] in, input logic rst, input bit chk_v);
    in_signal = in;
    reset     = rst;
    @(posedge clk);
    #1;
    model_edge(in, rst);
    check("out_spk", 32'(out_spk), 32'(m_spk));
    if (chk_v) begin
      for (int j = 0; j < 8; j++) check("potential", 32'(dut.v_q[j]), 32'(m_v[j]));
    end
  endtask

  initial begin
    logic [15:0] r;
    in_signal = '0;
    reset     = 1'b1;

    // Reset, then 20 idle cycles.
    step(16'h0000, 1'b1, 1'b1);
    check("reset_spk", 32'(out_spk), 32'h00);
    for (int n = 0; n < 20; n++) begin
      step(16'h0000, 1'b0, 1'b0);
      check("idle_spk", 32'(out_spk), 32'h00);
    end

    // 0x0003: fires every third edge.
    step(16'h0000, 1'b1, 1'b0);
    for (int n = 1; n <= 9; n++) begin
      step(16'h0003, 1'b0, 1'b1);
      check("in3_spk", 32'(out_spk), (n % 3 == 0) ? 32'h01 : 32'h00);
    end

    // 0x0001: fires every seventh edge.
    step(16'h0000, 1'b1, 1'b0);
    for (int n = 1; n <= 14; n++) begin
      step(16'h0001, 1'b0, 1'b1);
      check("in1_spk", 32'(out_spk), (n % 7 == 0) ? 32'h01 : 32'h00);
    end
    check("in1_v0_after14", 32'(dut.v_q[0]), 32'd0);

    // All inputs active: every neuron clamps at zero.
    step(16'h0000, 1'b1, 1'b0);
    for (int n = 0; n < 50; n++) begin
      step(16'hFFFF, 1'b0, 1'b0);
      check("ffff_spk", 32'(out_spk), 32'h00);
    end
    check("ffff_v7", 32'(dut.v_q[7]), 32'd0);

    // 0xC003: neurons 0 and 7 fire together at edge 5.
    step(16'h0000, 1'b1, 1'b0);
    for (int n = 1; n <= 5; n++) begin
      step(16'hC003, 1'b0, 1'b1);
      check("c003_spk", 32'(out_spk), (n == 5) ? 32'h81 : 32'h00);
    end

    // A reset in the middle of integration discards the potential.
    step(16'h0000, 1'b1, 1'b0);
    step(16'h0003, 1'b0, 1'b0);
    step(16'h0003, 1'b0, 1'b0);
    check("mid_v0", 32'(dut.v_q[0]), 32'd12);
    step(16'h0003, 1'b1, 1'b1);
    for (int n = 1; n <= 3; n++) begin
      step(16'h0003, 1'b0, 1'b0);
      check("mid_rst_spk", 32'(out_spk), (n == 3) ? 32'h01 : 32'h00);
    end

    // Random sparse and dense vectors, with an occasional reset.
    for (int n = 0; n < 400; n++) begin
      r = 16'($urandom);
      if (n % 3 == 0) r = r & 16'($urandom) & 16'($urandom);
      step(r, ($urandom_range(0, 49) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
